// File: rtl/instruction_encoder.sv
// RV32I field-bundle to instruction-word encoder with a running byte address; one output register stage (accept at edge N, valid after N).
// in_ready = !out_valid | out_ready; a stalled word holds instr/addr/err stable; restart drops it and rewinds the address.
module instruction_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_ISHFT = 3'd6,
        FMT_RSV   = 3'd7
    } fmt_e;

    fmt_e fmt_sel;
    assign fmt_sel = fmt_e'(fmt);

    // Signed range checks reduce to "all bits above the field equal the field's sign bit".
    logic imm_fits12;
    logic imm_fits13;
    logic imm_fits21;
    logic imm_even;
    logic imm_low12_zero;
    logic imm_shamt_ok;

    assign imm_fits12     = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm_fits13     = (&imm[31:12]) | ~(|imm[31:12]);
    assign imm_fits21     = (&imm[31:20]) | ~(|imm[31:20]);
    assign imm_even       = ~imm[0];
    assign imm_low12_zero = ~(|imm[11:0]);
    assign imm_shamt_ok   = ~(|imm[31:5]);

    logic [31:0] enc_instr;
    logic        enc_err;

    always_comb begin
        enc_instr = NOP_INSTR;
        enc_err   = 1'b0;
        case (fmt_sel)
            FMT_R: begin
                enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err   = ~imm_fits12;
            end
            FMT_S: begin
                enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err   = ~imm_fits12;
            end
            FMT_B: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err   = ~(imm_fits13 & imm_even);
            end
            FMT_U: begin
                enc_instr = {imm[31:12], rd, opcode};
                enc_err   = ~imm_low12_zero;
            end
            FMT_J: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err   = ~(imm_fits21 & imm_even);
            end
            FMT_ISHFT: begin
                enc_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                enc_err   = ~imm_shamt_ok;
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        if (enc_err) begin
            enc_instr = NOP_INSTR;
        end
    end

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_addr_q,  out_addr_d;
    logic        out_err_q,   out_err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic accept;
    logic out_hs;

    // Restart (and reset) blocks acceptance so a dropped stream cannot leak a word.
    assign in_ready = rst_n & ~restart & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign out_hs   = out_valid_q & out_ready & ~restart;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        if (restart) begin
            out_valid_d = 1'b0;
            out_addr_d  = BASE_ADDR;
        end else begin
            if (out_hs) begin
                out_valid_d = 1'b0;
                out_addr_d  = out_addr_q + 32'd4;
                if (out_err_q && (err_count_q != 8'hFF)) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
            if (accept) begin
                out_valid_d = 1'b1;
                out_instr_d = enc_instr;
                out_err_d   = enc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0000_0000;
            out_addr_q  <= BASE_ADDR;
            out_err_q   <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed scenarios plus a randomized run against a field-arithmetic reference model.
module tb_instruction_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n, restart, in_valid, in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    instruction_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference: each field weighted by its bit position; range rules on the signed value.
    task automatic model_encode(input int unsigned f, op, d, s1, s2, f3, f7,
                                input logic [31:0] im,
                                output logic [31:0] w_o, output logic e_o);
        int unsigned u, w;
        int s;
        bit e;
        u = im;
        s = $signed(im);
        e = 0;
        w = 0;
        case (f)
            0: w = f7 * 33554432 + s2 * 1048576 + s1 * 32768 + f3 * 4096 + d * 128 + op;
            1: begin
                e = (s < -2048) || (s > 2047);
                w = (u % 4096) * 1048576 + s1 * 32768 + f3 * 4096 + d * 128 + op;
            end
            2: begin
                e = (s < -2048) || (s > 2047);
                w = ((u / 32) % 128) * 33554432 + s2 * 1048576 + s1 * 32768 + f3 * 4096
                    + (u % 32) * 128 + op;
            end
            3: begin
                e = (s < -4096) || (s > 4094) || (u % 2 != 0);
                w = ((u / 4096) % 2) * 32'h8000_0000 + ((u / 32) % 64) * 33554432
                    + s2 * 1048576 + s1 * 32768 + f3 * 4096 + ((u / 2) % 16) * 256
                    + ((u / 2048) % 2) * 128 + op;
            end
            4: begin
                e = (u % 4096) != 0;
                w = (u / 4096) * 4096 + d * 128 + op;
            end
            5: begin
                e = (s < -1048576) || (s > 1048574) || (u % 2 != 0);
                w = ((u / 1048576) % 2) * 32'h8000_0000 + ((u / 2) % 1024) * 2097152
                    + ((u / 2048) % 2) * 1048576 + ((u / 4096) % 256) * 4096 + d * 128 + op;
            end
            6: begin
                e = u > 31;
                w = f7 * 33554432 + (u % 32) * 1048576 + s1 * 32768 + f3 * 4096 + d * 128 + op;
            end
            default: e = 1;
        endcase
        if (e) w = 32'h0000_0013;
        w_o = w;
        e_o = e;
    endtask

    task automatic drive(input int unsigned f, op, d, s1, s2, f3, f7, input logic [31:0] im);
        fmt = 3'(f); opcode = 7'(op); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
        funct3 = 3'(f3); funct7 = 7'(f7); imm = im;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", out_instr); end
        checks++; if (out_addr !== BASE) begin errors++; $display("FAIL rst_addr got %h want %h", out_addr, BASE); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", out_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_errcnt got %0d want 0", err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        apply_reset();
        drive(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
        checks++; if (out_instr !== 32'h0050_0093) begin errors++; $display("FAIL addi_instr got %h want 00500093", out_instr); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL addi_addr got %h want 0", out_addr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL addi_err got %b want 0", out_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hFE21_AE23; exp_w[1] = 32'hFE00_0CE3; exp_w[2] = 32'h0010_00EF;
        apply_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(2, 7'h23, 0, 3, 2, 2, 0, -32'sd4);
                1: drive(3, 7'h63, 0, 0, 0, 0, 0, -32'sd8);
                default: drive(5, 7'h6F, 1, 0, 0, 0, 0, 32'd2048);
            endcase
            @(negedge clk);
            checks++; if (out_instr !== exp_w[i] || out_valid !== 1'b1)
                begin errors++; $display("FAIL b2b_instr%0d got %h/%b want %h/1", i, out_instr, out_valid, exp_w[i]); end
            checks++; if (out_addr !== 32'(4 * i)) begin errors++; $display("FAIL b2b_addr%0d got %h want %h", i, out_addr, 4 * i); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_addr !== 32'hC)
            begin errors++; $display("FAIL b2b_drain got %b/%h want 0/0000000c", out_valid, out_addr); end
    endtask

    task automatic test_range_errors();
        logic exp_e [3];
        exp_e[0] = 1'b1; exp_e[1] = 1'b0; exp_e[2] = 1'b1;
        apply_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(1, 7'h13, 1, 0, 0, 0, 0, 32'd2048);
                1: drive(3, 7'h63, 0, 1, 2, 0, 0, 32'd6);
                default: drive(3, 7'h63, 0, 1, 2, 0, 0, 32'd3);
            endcase
            @(negedge clk);
            checks++; if (out_err !== exp_e[i]) begin errors++; $display("FAIL rng_err%0d got %b want %b", i, out_err, exp_e[i]); end
            if (exp_e[i]) begin
                checks++; if (out_instr !== 32'h13) begin errors++; $display("FAIL rng_nop%0d got %h want 00000013", i, out_instr); end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL rng_errcnt got %0d want 2", err_count); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive(0, 7'h33, 5, 6, 7, 0, 0, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        drive(0, 7'h33, 8, 9, 10, 0, 32, 32'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", c, in_ready); end
            checks++; if (out_instr !== 32'h0073_02B3 || out_addr !== 32'h0 || out_valid !== 1'b1)
                begin errors++; $display("FAIL bp_hold%0d got %h@%h want 007302b3@0", c, out_instr, out_addr); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", in_ready); end
        @(negedge clk);
        checks++; if (out_instr !== 32'h40A4_8433 || out_addr !== 32'h4)
            begin errors++; $display("FAIL bp_w1 got %h@%h want 40a48433@4", out_instr, out_addr); end
        drive(4, 7'h37, 3, 0, 0, 0, 0, 32'h1234_5000);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_instr !== 32'h1234_51B7 || out_addr !== 32'h8)
            begin errors++; $display("FAIL bp_w2 got %h@%h want 123451b7@8", out_instr, out_addr); end
    endtask

    task automatic test_restart();
        apply_reset();
        drive(7, 0, 0, 0, 0, 0, 0, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        drive(1, 7'h13, 2, 2, 0, 0, 0, 32'd1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_addr !== 32'h4)
            begin errors++; $display("FAIL rs_pending got %b@%h want 1@4", out_valid, out_addr); end
        restart = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rs_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        restart = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b want 0", out_valid); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL rs_errcnt got %0d want 1", err_count); end
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_addr !== BASE || out_instr !== 32'h0011_0113)
            begin errors++; $display("FAIL rs_next got %b %h@%h want 1 00110113@%h", out_valid, out_instr, out_addr, BASE); end
    endtask

    task automatic test_random();
        int edges [14];
        logic        ev, ee;
        logic [31:0] ei, ea, w;
        logic        e, erdy;
        int unsigned cnt, f, op, d, s1, s2, f3, f7;
        logic [31:0] im;
        bit iv, ordy, rst_req;
        edges = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                  1048574, -1048576, 1048576, 31, 32, 32'h1234_5000};
        apply_reset();
        ev = 0; ee = 0; ei = 0; ea = BASE; cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            #1;
            checks++; if (out_valid !== ev || out_addr !== ea || err_count !== 8'(cnt))
                begin errors++; $display("FAIL rnd_state c%0d got v%b a%h n%0d want v%b a%h n%0d",
                                         cyc, out_valid, out_addr, err_count, ev, ea, cnt); end
            if (ev) begin
                checks++; if (out_instr !== ei || out_err !== ee)
                    begin errors++; $display("FAIL rnd_word c%0d got %h/%b want %h/%b", cyc, out_instr, out_err, ei, ee); end
            end
            f = $urandom_range(0, 7); op = $urandom_range(0, 127); d = $urandom_range(0, 31);
            s1 = $urandom_range(0, 31); s2 = $urandom_range(0, 31);
            f3 = $urandom_range(0, 7); f7 = $urandom_range(0, 127);
            case ($urandom_range(0, 2))
                0: im = edges[$urandom_range(0, 13)];
                1: im = 32'($urandom_range(0, 80)) - 32'd40;
                default: im = $urandom;
            endcase
            iv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            rst_req = ($urandom_range(0, 40) == 0);
            drive(f, op, d, s1, s2, f3, f7, im);
            in_valid = iv; out_ready = ordy; restart = rst_req;
            #1;
            erdy = !rst_req && (!ev || ordy);
            checks++; if (in_ready !== erdy) begin errors++; $display("FAIL rnd_in_ready c%0d got %b want %b", cyc, in_ready, erdy); end
            if (rst_req) begin
                ev = 0; ea = BASE;
            end else begin
                if (ev && ordy) begin
                    ea = ea + 4;
                    if (ee && cnt < 255) cnt++;
                    ev = 0;
                end
                if (iv && erdy) begin
                    model_encode(f, op, d, s1, s2, f3, f7, im, w, e);
                    ev = 1; ei = w; ee = e;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0; restart = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_saturation();
        int exp_n;
        apply_reset();
        drive(7, 0, 0, 0, 0, 0, 0, 32'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int p = 1; p <= 260; p++) begin
            @(negedge clk);
            exp_n = (p - 1 > 255) ? 255 : p - 1;
            checks++; if (err_count !== 8'(exp_n) || out_addr !== 32'(4 * (p - 1)))
                begin errors++; $display("FAIL sat_p%0d got n%0d a%h want n%0d a%h", p, err_count, out_addr, exp_n, 4 * (p - 1)); end
        end
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || err_count !== 8'd255)
            begin errors++; $display("FAIL sat_hold got v%b e%b n%0d want v1 e1 n255", out_valid, out_err, err_count); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== BASE || out_err !== 1'b0 || err_count !== 8'd0)
            begin errors++; $display("FAIL rst2_outputs got v%b i%h a%h e%b n%0d want all reset",
                                     out_valid, out_instr, out_addr, out_err, err_count); end
        checks++; if (in_ready !== 1'b0 && in_ready !== 1'b1) begin errors++; $display("FAIL rst2_ready_x got %b", in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst2_in_ready got %b want 1", in_ready); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_addi();
        test_back_to_back();
        test_range_errors();
        test_backpressure();
        test_restart();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
